// File: rtl/calculator_pkg.sv
// Shared definitions for the RPN calculator and its key front-end:
// operand width and command priority order.
package calculator_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_ENTER    = 2'd1,
        CMD_ADD      = 2'd2,
        CMD_MULTIPLY = 2'd3
    } cmd_t;

    // Fixed priority: enter > add > multiply; losers are dropped.
    function automatic cmd_t pick_command(input logic enter_press,
                                          input logic add_press,
                                          input logic multiply_press);
        if (enter_press) begin
            return CMD_ENTER;
        end else if (add_press) begin
            return CMD_ADD;
        end else if (multiply_press) begin
            return CMD_MULTIPLY;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One raw push-button: 2-flop synchroniser, hold-time debounce counter,
// and a single-cycle press indication on each accepted rising level.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            s1       <= key;
            s2       <= s1;
            stable_d <= stable;
            // Any return to the accepted level restarts the hold count.
            if (s2 == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                stable <= s2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/calculator_keys.sv
// Board-pin front-end for the RPN calculator: debounced, arbitrated
// one-cycle command strobes plus a synchronised operand bus.
module calculator_keys #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_WIDTH      = calculator_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_enter,
    input  logic                  key_add,
    input  logic                  key_multiply,
    input  logic [DATA_WIDTH-1:0] switches,
    output logic                  enter,
    output logic                  add,
    output logic                  multiply,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  collision
);

    import calculator_pkg::*;

    logic                  enter_press;
    logic                  add_press;
    logic                  multiply_press;
    logic [DATA_WIDTH-1:0] sw_s1;
    logic [DATA_WIDTH-1:0] sw_s2;
    cmd_t                  cmd;
    logic                  multi;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock (clock),
        .reset (reset),
        .key   (key_enter),
        .press (enter_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .clock (clock),
        .reset (reset),
        .key   (key_add),
        .press (add_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_multiply (
        .clock (clock),
        .reset (reset),
        .key   (key_multiply),
        .press (multiply_press)
    );

    always_comb begin
        cmd   = pick_command(enter_press, add_press, multiply_press);
        multi = (enter_press & add_press) | (enter_press & multiply_press) |
                (add_press & multiply_press);
    end

    // Switches are only synchronised: they settle long before any strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            data      <= '0;
            enter     <= 1'b0;
            add       <= 1'b0;
            multiply  <= 1'b0;
            collision <= 1'b0;
        end else begin
            sw_s1     <= switches;
            sw_s2     <= sw_s1;
            data      <= sw_s2;
            enter     <= (cmd == CMD_ENTER);
            add       <= (cmd == CMD_ADD);
            multiply  <= (cmd == CMD_MULTIPLY);
            collision <= multi;
        end
    end

endmodule

// File: tb/tb_calculator_keys.sv
// Self-checking bench for calculator_keys with DEBOUNCE_CYCLES=4.
module tb_calculator_keys;

    localparam int DB  = 4;
    localparam int DW  = 8;
    localparam int LAT = DB + 3;  // key driven at a negedge -> strobe seen LAT negedges later

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          key_enter = 1'b0;
    logic          key_add = 1'b0;
    logic          key_multiply = 1'b0;
    logic [DW-1:0] switches = '0;
    logic          enter;
    logic          add;
    logic          multiply;
    logic [DW-1:0] data;
    logic          collision;

    calculator_keys #(.DEBOUNCE_CYCLES(DB), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_enter    (key_enter),
        .key_add      (key_add),
        .key_multiply (key_multiply),
        .switches     (switches),
        .enter        (enter),
        .add          (add),
        .multiply     (multiply),
        .data         (data),
        .collision    (collision)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          at;
        logic [2:0]  cmd;       // {enter, add, multiply}
        logic        coll;
        logic        chk_data;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] stack[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_strobe(input int at, input logic [2:0] cmd, input logic coll,
                                 input logic cd, input logic [DW-1:0] d);
        exp_t e;
        e.at = at; e.cmd = cmd; e.coll = coll; e.chk_data = cd; e.dat = d;
        sb.push_back(e);
    endtask

    // Press a key combination ({enter, add, multiply}) with the given switches, then release.
    task automatic press_keys(input logic [2:0] k, input logic [DW-1:0] sw,
                              input logic [2:0] exp_cmd, input logic exp_coll);
        switches = sw;
        {key_enter, key_add, key_multiply} = k;
        expect_strobe(cyc + LAT, exp_cmd, exp_coll, exp_cmd[2], sw);
        tick(12);
        {key_enter, key_add, key_multiply} = 3'b000;
        tick(12);
        chk("pending_strobes", sb.size(), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard; feeds an RPN model.
    logic [2:0]  mon_s;
    exp_t        mon_e;
    logic [15:0] op_a;
    logic [15:0] op_b;
    always @(negedge clock) begin
        mon_s = {enter, add, multiply};
        if (!reset) begin
            chk("quiet_in_reset", {28'd0, mon_s, collision}, 32'd0);
        end else if (mon_s != 3'b000 || collision) begin
            chk("one_hot", ($countones(mon_s) <= 1), 1);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {28'd0, mon_s, collision}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_cycle", cyc, mon_e.at);
                chk("strobe_cmd", mon_s, mon_e.cmd);
                chk("collision", collision, mon_e.coll);
                if (mon_e.chk_data) chk("enter_data", data, mon_e.dat);
            end
            if (enter) begin
                stack.push_back({8'd0, data});
            end else if ((add || multiply) && stack.size() >= 2) begin
                op_b = stack.pop_back();
                op_a = stack.pop_back();
                stack.push_back(add ? op_a + op_b : op_a * op_b);
            end
        end
    end

    typedef struct {
        logic [2:0] keys;
        logic [2:0] cmd;
        logic       coll;
    } arb_vec_t;

    arb_vec_t arb_tab[7];
    logic     bounce[5];

    initial begin
        arb_tab[0] = '{3'b100, 3'b100, 1'b0};
        arb_tab[1] = '{3'b010, 3'b010, 1'b0};
        arb_tab[2] = '{3'b001, 3'b001, 1'b0};
        arb_tab[3] = '{3'b110, 3'b100, 1'b1};
        arb_tab[4] = '{3'b101, 3'b100, 1'b1};
        arb_tab[5] = '{3'b011, 3'b010, 1'b1};
        arb_tab[6] = '{3'b111, 3'b100, 1'b1};
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset with switches present: data appears on the third edge after release.
        #1 reset = 1'b0;
        switches = 8'h5A;
        tick(3);
        reset = 1'b1;
        tick(2);
        chk("data_after_2_edges", data, 8'h00);
        tick(1);
        chk("data_after_3_edges", data, 8'h5A);
        chk("no_strobe_after_reset", {enter, add, multiply, collision}, 4'b0000);
        tick(5);

        // Clean enter press held 20 cycles.
        key_enter = 1'b1;
        expect_strobe(cyc + LAT, 3'b100, 1'b0, 1'b1, 8'h5A);
        tick(20);
        key_enter = 1'b0;
        tick(12);
        chk("pending_clean_enter", sb.size(), 0);

        // Bouncing add: short bursts ignored, count restarts from the last rise.
        foreach (bounce[i]) begin
            key_add = bounce[i];
            tick(1);
        end
        key_add = 1'b1;
        expect_strobe(cyc + LAT, 3'b010, 1'b0, 1'b0, '0);
        tick(20);
        key_add = 1'b0;
        tick(12);
        chk("pending_bounce_add", sb.size(), 0);

        // Arbitration table.
        for (int i = 0; i < 7; i++) begin
            press_keys(arb_tab[i].keys, 8'h11 * i[7:0], arb_tab[i].cmd, arb_tab[i].coll);
        end

        // RPN sequence: 2 3 * -> 6, then 4 5 * + -> 26.
        stack.delete();
        press_keys(3'b100, 8'h02, 3'b100, 1'b0);
        press_keys(3'b100, 8'h03, 3'b100, 1'b0);
        press_keys(3'b001, 8'h03, 3'b001, 1'b0);
        chk("rpn_depth_1", stack.size(), 1);
        if (stack.size() > 0) chk("rpn_result_0006", stack[stack.size()-1], 16'h0006);
        press_keys(3'b100, 8'h04, 3'b100, 1'b0);
        press_keys(3'b100, 8'h05, 3'b100, 1'b0);
        press_keys(3'b001, 8'h05, 3'b001, 1'b0);
        press_keys(3'b010, 8'h05, 3'b010, 1'b0);
        chk("rpn_depth_2", stack.size(), 1);
        if (stack.size() > 0) chk("rpn_result_001A", stack[stack.size()-1], 16'h001A);

        // Reset two cycles into a multiply debounce, key still held at release.
        key_multiply = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        reset = 1'b1;
        expect_strobe(cyc + LAT, 3'b001, 1'b0, 1'b0, '0);
        tick(20);
        key_multiply = 1'b0;
        tick(12);
        chk("pending_reset_multiply", sb.size(), 0);

        // Reset landing on a strobe clears it at once; no stale strobe afterwards.
        key_add = 1'b1;
        expect_strobe(cyc + LAT, 3'b010, 1'b0, 1'b0, '0);
        tick(LAT);
        #2 reset = 1'b0;
        #1 chk("strobe_cleared_by_reset", {enter, add, multiply, collision}, 4'b0000);
        key_add = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(15);
        chk("pending_after_strobe_reset", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_keys.md
# calculator_keys

Front-end for the RPN calculator: takes three raw push-buttons and an 8-bit switch bank from the board and produces the clean, synchronous, single-cycle `enter` / `add` / `multiply` strobes and stable `data` bus the calculator consumes. It synchronises every asynchronous input, debounces each key and converts each debounced press into exactly one one-cycle pulse. It also guarantees that at most one command strobe is high in any cycle. It sits between the board pins and the calculator's command inputs.

## Interface
- `DEBOUNCE_CYCLES`, 16: cycles a synchronised key must hold a new level before it is accepted; legal range ≥ 2 (board build overrides, e.g. 500000).
- `DATA_WIDTH`, 8: switch/data width; must match the calculator operand width.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `key_enter`, `key_add`, `key_multiply`  in  1 each  raw buttons, asynchronous, active-high, bouncing.
- `switches`  in  DATA_WIDTH  raw operand switches, asynchronous.
- `enter`, `add`, `multiply`  out  1 each  registered one-cycle command strobes to the calculator.
- `data`  out  DATA_WIDTH  registered operand to the calculator.
- `collision`  out  1  registered one-cycle flag: two or more presses were accepted in the same cycle.

## Operation
- Each key and each switch bit passes through a 2-flop synchroniser (`s1`, `s2`).
- Per key, a debounce counter (width `$clog2(DEBOUNCE_CYCLES)`) and a `stable` bit:
  - `s2 == stable`: counter ← 0.
  - `s2 != stable`, counter < DEBOUNCE_CYCLES−1: counter increments.
  - `s2 != stable`, counter == DEBOUNCE_CYCLES−1: `stable` ← `s2`, counter ← 0.
- Press event = `stable` rises. Release produces no event. Holding a key produces exactly one event.
- Arbitration when several press events occur in one cycle: priority enter > add > multiply. Only the winner pulses; the losers are dropped, not queued. `collision` pulses in the same cycle as the winner.
- `data` loads the synchronised switches every cycle. The switches are not debounced: they have settled long before an enter strobe can occur.
- Outputs are mutually one-hot-or-zero at all times.

## Timing
- Reset (asynchronous assert, synchronous release): all synchroniser flops, `stable` bits, counters, strobes, `collision` and `data` go to 0.
- Key latency: raw key first sampled high at edge 0 → `s2` high after edge 1 → `stable` high after edge DEBOUNCE_CYCLES+1 → strobe high for exactly one cycle after edge DEBOUNCE_CYCLES+2.
- Glitches or bounces shorter than DEBOUNCE_CYCLES consecutive cycles at `s2` are ignored. Any bounce restarts the count.
- Minimum spacing between two strobes of the same key: 2·DEBOUNCE_CYCLES cycles (press, release, press).
- Switch latency: `data` reflects `switches` 3 edges after they change.
- Key held through reset release: `stable` starts at 0, so one press strobe is issued DEBOUNCE_CYCLES+2 cycles after release.
- Reset asserted mid-debounce or during a strobe: the strobe is cleared immediately and the count is lost. No stale strobe appears after release unless the key is still held.

## Structure
- Shared package `calculator_pkg`: `DATA_WIDTH` and the command priority order. Both this block and the calculator use these.
- Sub-module `key_debouncer` (2-flop synchroniser, counter, `stable`, rising-edge detect; parameter DEBOUNCE_CYCLES) is instantiated three times.
- Top level contains the switch synchroniser, the priority arbiter and the output registers.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset with switches=8'h5A and no keys → after 3 cycles `data`=5A, no strobes, `collision`=0.
- Clean `key_enter` press held 20 cycles → single `enter` pulse one cycle wide, exactly 6 edges after first sample; `add`=`multiply`=0.
- `key_add` bounce 1,0,1,1,0 (cycles), then steady high → one `add` pulse, timed from the last rising bounce +6 edges; no pulse from the short bursts.
- `key_enter` and `key_multiply` rise on the same cycle → only `enter` pulses, `collision` pulses in the same cycle, no later `multiply` pulse while it is held.
- Full sequence: switches=02, enter; 03, enter; multiply → calculator result=0006. Then 04, 05, multiply, add → result=001A, with `data` stable at each enter strobe.
- Assert `reset` 2 cycles into a `key_multiply` debounce, release while the key is still held → no strobe during reset, one `multiply` 6 edges after release.
